// File: rtl/rvga_types.sv
// Shared load/store types: bus FSM states, funct3 encodings, lane and legality helpers.
package rvga_types;

  typedef logic [31:0] rvga_word;
  typedef logic [2:0]  rvga_funct3;
  typedef logic [3:0]  rvga_be;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} rvga_mem_state_e;

  localparam rvga_funct3 F3_LB  = 3'b000;
  localparam rvga_funct3 F3_LH  = 3'b001;
  localparam rvga_funct3 F3_LW  = 3'b010;
  localparam rvga_funct3 F3_LBU = 3'b100;
  localparam rvga_funct3 F3_LHU = 3'b101;
  localparam rvga_funct3 F3_SB  = 3'b000;
  localparam rvga_funct3 F3_SH  = 3'b001;
  localparam rvga_funct3 F3_SW  = 3'b010;

  typedef struct packed {
    logic       we;
    rvga_funct3 op;
    rvga_word   addr;
    rvga_word   data;
  } rvga_mem_req_t;

  // op[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word.
  function automatic logic rvga_is_misaligned(input rvga_funct3 op, input logic [1:0] off);
    case (op[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rvga_is_illegal(input logic we, input rvga_funct3 op);
    if (we) return op != F3_SB && op != F3_SH && op != F3_SW;
    return op != F3_LB && op != F3_LH && op != F3_LW && op != F3_LBU && op != F3_LHU;
  endfunction

  function automatic rvga_be rvga_be_gen(input rvga_funct3 op, input logic [1:0] off);
    case (op[1:0])
      2'b00:   return rvga_be'(4'b0001 << off);
      2'b01:   return rvga_be'(4'b0011 << off);
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_slicer.sv
// Combinational load extension and store truncation; zero latency, no flow control.
module memory_slicer
  import rvga_types::*;
(
  input  rvga_funct3 op_i,
  input  rvga_word   ld_data_i,
  input  rvga_word   st_data_i,
  output rvga_word   ld_result_o,
  output rvga_word   st_result_o
);

  always_comb begin
    ld_result_o = '0;
    st_result_o = '0;
    case (op_i)
      F3_LB:   ld_result_o = {{24{ld_data_i[7]}}, ld_data_i[7:0]};
      F3_LH:   ld_result_o = {{16{ld_data_i[15]}}, ld_data_i[15:0]};
      F3_LW:   ld_result_o = ld_data_i;
      F3_LBU:  ld_result_o = {24'b0, ld_data_i[7:0]};
      F3_LHU:  ld_result_o = {16'b0, ld_data_i[15:0]};
      default: ld_result_o = '0;
    endcase
    case (op_i[1:0])
      2'b00:   st_result_o = {24'b0, st_data_i[7:0]};
      2'b01:   st_result_o = {16'b0, st_data_i[15:0]};
      default: st_result_o = st_data_i;
    endcase
  end

endmodule

// File: rtl/memory_access_ctrl.sv
// Single-outstanding load/store sequencer to the dmem bus; min latency 3 cycles (1 if rejected).
// Backpressure: req_ready_o only in IDLE; response held until resp_ready_i, grant wait unbounded.
module memory_access_ctrl
  import rvga_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_v_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        resp_v_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_misalign_o,
  output logic        resp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  rvga_mem_state_e      state_q, state_d;
  rvga_mem_req_t        req_q, req_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  rvga_word             resp_data_q, resp_data_d;
  logic                 resp_misalign_q, resp_misalign_d;
  logic                 resp_err_q, resp_err_d;

  logic [1:0] off;
  rvga_word   ld_shifted;
  rvga_word   ld_result;
  rvga_word   st_result;

  assign off        = req_q.addr[1:0];
  assign ld_shifted = mem_rdata_i >> {off, 3'b000};

  memory_slicer u_slicer (
    .op_i        (req_q.op),
    .ld_data_i   (ld_shifted),
    .st_data_i   (req_q.data),
    .ld_result_o (ld_result),
    .st_result_o (st_result)
  );

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    cnt_d           = cnt_q;
    resp_data_d     = resp_data_q;
    resp_misalign_d = resp_misalign_q;
    resp_err_d      = resp_err_q;

    req_ready_o     = 1'b0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_be_o        = '0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    resp_v_o        = 1'b0;
    resp_data_o     = '0;
    resp_misalign_o = 1'b0;
    resp_err_o      = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_v_i) begin
          req_d = '{we: req_we_i, op: req_op_i, addr: req_addr_i, data: req_data_i};
          if (rvga_is_misaligned(req_op_i, req_addr_i[1:0]) ||
              rvga_is_illegal(req_we_i, req_op_i)) begin
            state_d         = RESP;
            resp_misalign_d = 1'b1;
            resp_err_d      = 1'b0;
            resp_data_d     = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = req_q.we;
        mem_be_o    = req_q.we ? rvga_be_gen(req_q.op, off) : 4'b1111;
        mem_addr_o  = {req_q.addr[31:2], 2'b00};
        mem_wdata_o = st_result << {off, 3'b000};
        if (mem_gnt_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (mem_rvalid_i) begin
          state_d         = RESP;
          resp_data_d     = req_q.we ? '0 : ld_result;
          resp_misalign_d = 1'b0;
          resp_err_d      = 1'b0;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d         = RESP;
          resp_data_d     = '0;
          resp_misalign_d = 1'b0;
          resp_err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      RESP: begin
        resp_v_o        = 1'b1;
        resp_data_o     = resp_data_q;
        resp_misalign_o = resp_misalign_q;
        resp_err_o      = resp_err_q;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q         <= IDLE;
      req_q           <= '0;
      cnt_q           <= '0;
      resp_data_q     <= '0;
      resp_misalign_q <= 1'b0;
      resp_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      cnt_q           <= cnt_d;
      resp_data_q     <= resp_data_d;
      resp_misalign_q <= resp_misalign_d;
      resp_err_q      <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Directed bench for memory_access_ctrl: vector table plus timeout, reset and stall sequences.
module tb_memory_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_v, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_data;
  logic        resp_v, resp_ready, resp_misalign, resp_err;
  logic [31:0] resp_data;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .req_v_i         (req_v),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_op_i        (req_op),
    .req_addr_i      (req_addr),
    .req_data_i      (req_data),
    .resp_v_o        (resp_v),
    .resp_ready_i    (resp_ready),
    .resp_data_o     (resp_data),
    .resp_misalign_o (resp_misalign),
    .resp_err_o      (resp_err),
    .mem_req_o       (mem_req),
    .mem_gnt_i       (mem_gnt),
    .mem_we_o        (mem_we),
    .mem_be_o        (mem_be),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] resp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
    check({tag, " req_ready before accept"}, {31'b0, req_ready}, 32'd1);
    req_v = 1'b1; req_we = we; req_op = op; req_addr = addr; req_data = data;
    @(negedge clk);
    req_v = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " resp_v after ack"}, {31'b0, resp_v}, 32'd0);
    check({tag, " req_ready after ack"}, {31'b0, req_ready}, 32'd1);
    check({tag, " mem_req idle"}, {31'b0, mem_req}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    send_req(v.we, v.op, v.addr, v.wdata, tag);
    if (v.mis) begin
      check({tag, " resp_v at N+1"}, {31'b0, resp_v}, 32'd1);
      check({tag, " misalign"}, {31'b0, resp_misalign}, 32'd1);
      check({tag, " mem_req"}, {31'b0, mem_req}, 32'd0);
      check({tag, " resp_data"}, resp_data, 32'd0);
      check({tag, " err"}, {31'b0, resp_err}, 32'd0);
    end else begin
      check({tag, " mem_req"}, {31'b0, mem_req}, 32'd1);
      check({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, v.we});
      check({tag, " mem_be"}, {28'b0, mem_be}, {28'b0, v.be});
      check({tag, " mem_addr"}, mem_addr, v.maddr);
      check({tag, " mem_wdata"}, mem_wdata, v.mwdata);
      check({tag, " resp_v early"}, {31'b0, resp_v}, 32'd0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check({tag, " mem_req in wait"}, {31'b0, mem_req}, 32'd0);
      check({tag, " resp_v in wait"}, {31'b0, resp_v}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check({tag, " resp_v at N+3"}, {31'b0, resp_v}, 32'd1);
      check({tag, " resp_data"}, resp_data, v.resp);
      check({tag, " misalign"}, {31'b0, resp_misalign}, 32'd0);
      check({tag, " err"}, {31'b0, resp_err}, 32'd0);
    end
    finish_resp(tag);
  endtask

  // Runs a load that gets granted but answers (or not) only on the 4th WAIT cycle.
  task automatic timeout_seq(input logic late_ok, input logic [31:0] rdata, input string tag);
    send_req(1'b0, 3'b010, 32'h20, 32'h0, tag);
    check({tag, " mem_req"}, {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s resp_v wait%0d", tag, i + 1), {31'b0, resp_v}, 32'd0);
      if (i == 3 && late_ok) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    check({tag, " resp_v"}, {31'b0, resp_v}, 32'd1);
    check({tag, " err"}, {31'b0, resp_err}, late_ok ? 32'd0 : 32'd1);
    check({tag, " resp_data"}, resp_data, late_ok ? rdata : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 4'hF, 32'h100, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 4'hF, 32'h100, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1'b0, 4'hC, 32'h200, 32'hABCD0000, 32'h0};
    vecs[4]  = '{1'b1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0,        1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[5]  = '{1'b0, 3'b001, 32'h001, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[6]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1'b0, 4'hF, 32'h100, 32'h0,        32'hFFFF8001};
    vecs[7]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h80011234, 1'b0, 4'hF, 32'h100, 32'h0,        32'h00008001};
    vecs[8]  = '{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        1'b0, 4'h2, 32'h300, 32'h0000A500, 32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h004, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,   32'h0,        32'h0};
    vecs[11] = '{1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF, 32'h400, 32'hCAFEF00D, 32'h0};

    reset_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset mem_req", {31'b0, mem_req}, 32'd0);
    check("reset resp_v", {31'b0, resp_v}, 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    check("reset err/misalign", {30'b0, resp_err, resp_misalign}, 32'd0);
    check("reset mem_be", {28'b0, mem_be}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout, then a stray rvalid in RESP and IDLE must not disturb anything.
    timeout_seq(1'b0, 32'h0, "timeout");
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("timeout held resp_v", {31'b0, resp_v}, 32'd1);
    check("timeout held data", resp_data, 32'd0);
    check("timeout held err", {31'b0, resp_err}, 32'd1);
    finish_resp("timeout");
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late rvalid idle resp_v", {31'b0, resp_v}, 32'd0);
    run_vec(vecs[0], "after timeout");

    timeout_seq(1'b1, 32'h11223344, "rvalid on timeout");
    finish_resp("rvalid on timeout");

    // Reset while the bus request is pending and ungranted.
    send_req(1'b0, 3'b010, 32'h30, 32'h0, "reset-in-issue");
    check("reset-in-issue mem_req", {31'b0, mem_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("reset-in-issue mem_req dropped", {31'b0, mem_req}, 32'd0);
    check("reset-in-issue req_ready", {31'b0, req_ready}, 32'd1);
    reset_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("post-reset rvalid resp_v", {31'b0, resp_v}, 32'd0);
    check("post-reset rvalid req_ready", {31'b0, req_ready}, 32'd1);

    // Response stalled for 5 cycles must hold steady.
    send_req(1'b0, 3'b010, 32'h40, 32'h0, "stall");
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A55A5A;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d resp_v", i), {31'b0, resp_v}, 32'd1);
      check($sformatf("stall%0d resp_data", i), resp_data, 32'hA5A55A5A);
      check($sformatf("stall%0d req_ready", i), {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    finish_resp("stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
